// File: rtl/divider_16x8_if.sv
// Handshake and result bundle shared by the divider and whatever drives it.
// The master side issues start/operands; the slave (the divider) returns results and status.
interface divider_16x8_if #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned DBITS = 8
);

  logic             start;
  logic [NBITS-1:0] dividend;
  logic [DBITS-1:0] divisor;
  logic [NBITS-1:0] quotient;
  logic [DBITS-1:0] remainder;
  logic             done_flag;
  logic             div_zero;
  logic             busy;
  logic             seg_a;
  logic             seg_b;
  logic             seg_c;
  logic             seg_d;
  logic             seg_e;
  logic             seg_f;
  logic             seg_g;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  quotient,
    input  remainder,
    input  done_flag,
    input  div_zero,
    input  busy,
    input  seg_a,
    input  seg_b,
    input  seg_c,
    input  seg_d,
    input  seg_e,
    input  seg_f,
    input  seg_g
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output quotient,
    output remainder,
    output done_flag,
    output div_zero,
    output busy,
    output seg_a,
    output seg_b,
    output seg_c,
    output seg_d,
    output seg_e,
    output seg_f,
    output seg_g
  );

endinterface

// File: rtl/divider_16x8.sv
// Sequential restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per clock.
// Shares the start/done_flag handshake and seven-segment state display with multiplier_8x8.
module divider_16x8 #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned DBITS = 8
) (
  input logic           clk,
  input logic           reset_a,
  divider_16x8_if.slave bus
);

  localparam int unsigned CntW = $clog2(NBITS) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NBITS - 1);

  // Segment patterns, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SegIdle = 7'b1111110;
  localparam logic [6:0] SegCalc = 7'b0110000;
  localparam logic [6:0] SegDone = 7'b1101101;
  localparam logic [6:0] SegErr  = 7'b1001111;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q;
  logic [NBITS-1:0] work_q;
  logic [DBITS-1:0] div_q;
  logic [DBITS-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;
  logic [NBITS-1:0] quotient_q;
  logic [DBITS-1:0] remainder_q;
  logic             done_q;
  logic             div_zero_q;
  logic             busy_q;
  logic [6:0]       seg_q;

  logic [DBITS:0]   r_shift;
  logic             r_ge;
  logic [DBITS-1:0] rem_d;
  logic [NBITS-1:0] work_d;

  // One restoring step: the 9-bit partial remainder only lives in r_shift, since after the
  // conditional subtract it is always below the divisor and fits in DBITS bits.
  always_comb begin
    r_shift = {rem_q, work_q[NBITS-1]};
    r_ge    = r_shift >= {1'b0, div_q};
    rem_d   = r_ge ? DBITS'(r_shift - {1'b0, div_q}) : r_shift[DBITS-1:0];
    work_d  = {work_q[NBITS-2:0], r_ge};
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q     <= StIdle;
      work_q      <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      seg_q       <= SegIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            work_q <= bus.dividend;
            div_q  <= bus.divisor;
            rem_q  <= '0;
            cnt_q  <= '0;
            if (bus.divisor != '0) begin
              state_q    <= StCalc;
              busy_q     <= 1'b1;
              done_q     <= 1'b0;
              div_zero_q <= 1'b0;
              seg_q      <= SegCalc;
            end else begin
              // Division by zero resolves on the accepting edge with a saturated quotient.
              state_q     <= StDone;
              quotient_q  <= '1;
              remainder_q <= bus.dividend[DBITS-1:0];
              done_q      <= 1'b1;
              div_zero_q  <= 1'b1;
              seg_q       <= SegErr;
            end
          end
        end
        StCalc: begin
          rem_q  <= rem_d;
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q     <= StDone;
            quotient_q  <= work_d;
            remainder_q <= rem_d;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            seg_q       <= SegDone;
          end
        end
        default: begin
          state_q <= StIdle;
          seg_q   <= SegIdle;
        end
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.done_flag = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.busy      = busy_q;
  assign {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g} = seg_q;

endmodule

// File: doc/divider_16x8.md
Name: divider_16x8

Overview:
- Sequential restoring divider: divides a 16-bit unsigned dividend by an 8-bit unsigned divisor, one quotient bit per clock.
- Inverse companion of multiplier_8x8. It uses the same start/done_flag handshake and seven-segment status display, so the two can sit side by side on the board.
- A divider_16x8 operation recovers both operands of a multiplier_8x8 product: dividend = product8_8, divisor = one operand; the quotient is the other operand and the remainder is 0.

Parameters:
- NBITS, 16, dividend/quotient width; also the number of CALC iterations.
- DBITS, 8, divisor/remainder width.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_a  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request pulse; sampled on rising clk edges.
- dividend  input  16  unsigned numerator, sampled when start is accepted.
- divisor  input  8  unsigned denominator, sampled when start is accepted.
- quotient  output  16  result quotient, valid while done_flag=1.
- remainder  output  8  result remainder, valid while done_flag=1.
- done_flag  output  1  result valid; stays high until the next accepted start.
- div_zero  output  1  the last operation had divisor=0.
- busy  output  1  high while in CALC.
- seg_a..seg_g  output  1 each  seven-segment state display, active-high.

Behaviour:
- Reset (reset_a=0, asynchronous):
  - state=IDLE, quotient=0, remainder=0, done_flag=0, div_zero=0, busy=0.
  - seg outputs show "0".
  - Internal shift registers and counter are cleared.
- States and display codes (segments a..g):
  - IDLE shows "0" = 1111110.
  - CALC shows "1" = 0110000.
  - DONE shows "2" = 1101101.
  - DONE with div_zero=1 shows "E" = 1001111.
- Start acceptance:
  - start=1 is accepted only at a rising edge in IDLE or DONE.
  - On that edge: latch dividend into the work register and divisor into the divisor register; clear the partial remainder (9 bits internally) and the 5-bit counter; clear done_flag and div_zero.
- Divisor nonzero path:
  - The accepting edge sets state=CALC, busy=1.
- Divisor zero path:
  - The accepting edge goes straight to DONE.
  - Outputs: quotient=16'hFFFF, remainder=dividend[7:0], div_zero=1, done_flag=1.
- Each CALC edge:
  - Partial remainder r = {r[7:0], work[15]}; work shifts left 1.
  - If r >= divisor: r = r - divisor and work[0]=1; else work[0]=0.
  - Counter increments.
- CALC exit:
  - The 16th CALC edge (counter reaches 15 before the increment) loads quotient=work and remainder=r[7:0].
  - On that edge: done_flag=1, busy=0, state=DONE.
- Latency: done_flag rises exactly 17 rising edges after the start-accept edge (1 accept + 16 CALC).
- start in CALC: ignored. Operands and outputs are unaffected; no queuing.
- DONE hold: outputs hold until the next accepted start or reset. There is no automatic return to IDLE.
- start held high continuously: in DONE it is re-accepted on the next edge, so back-to-back operations run with a 1-cycle DONE.
- Operand changes while not accepting a start have no effect.
- Reset mid-CALC: immediate abort to the reset values above. No partial result is exposed.
- Result identity (divisor nonzero): dividend = quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- Reset low, then high; start=1 for one cycle with dividend=50, divisor=5 → busy for 16 cycles; done_flag at edge 17; quotient=10, remainder=0; display "2".
- dividend=100, divisor=7 → quotient=14, remainder=2; then dividend=65535, divisor=1 → quotient=65535, remainder=0; then dividend=65535, divisor=255 → quotient=257, remainder=0.
- dividend=1234, divisor=0 → next edge: done_flag=1, div_zero=1, quotient=16'hFFFF, remainder=8'hD2, display "E"; a following valid start clears div_zero.
- Start 21/3, then pulse start with 200/9 at CALC cycle 5 → second request ignored; result quotient=7, remainder=0 at edge 17.
- Start 50/5, assert reset_a=0 mid-CALC (between edges) → outputs zero immediately; after release, done_flag stays 0 until a new start.
- Hold start=1 with 21/3 then 100/7 applied after done → each result appears 17 edges after its accept; DONE lasts one cycle between operations.
